bist_pattern_harness: RTL and testbench



---
 rtl/bist_pkg.sv | 33 +++
 rtl/galois_reg.sv | 35 +++
 rtl/bist_pattern_harness.sv | 131 +++++++++++++
 tb/tb_bist_pattern_harness.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared types and helpers for the BIST pattern harness: FSM state encoding,
// the Galois shift step used by both the pattern LFSR and the response MISR,
// and the zero-seed guard.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Widest register the Galois helper supports; both buses are zero-extended to it.
    localparam int MAX_W = 64;

    // One Galois step on the low 'width' bits: shift left, and fold the
    // polynomial back in when the bit shifted out was set.
    function automatic logic [MAX_W-1:0] galois_step(input logic [MAX_W-1:0] cur,
                                                     input logic [MAX_W-1:0] poly,
                                                     input int           width);
        logic [MAX_W-1:0] mask;
        logic             msb;
        mask = {MAX_W{1'b1}} >> (MAX_W - width);
        msb  = ((cur >> (width - 1)) & MAX_W'(1)) != '0;
        galois_step = ((cur << 1) & mask) ^ (msb ? (poly & mask) : '0);
    endfunction

    // An all-zero LFSR state is a lock-up state, so a zero seed becomes 1.
    function automatic logic [MAX_W-1:0] seed_guard(input logic [MAX_W-1:0] seed);
        seed_guard = (seed == '0) ? MAX_W'(1) : seed;
    endfunction

endpackage

// File: rtl/galois_reg.sv
// Galois shift register with synchronous load, step enable and an XOR-in port.
// With xor_in tied to zero it is a pattern LFSR; fed with a response it is a MISR.
module galois_reg
    import bist_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] POLY    = WIDTH'(1),
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] xor_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] next;

    // Next value: one Galois step on q, then absorb the XOR-in word.
    assign next = WIDTH'(galois_step(MAX_W'(q), MAX_W'(POLY), WIDTH)) ^ xor_in;

    // State register: load wins over a step; otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst)
            q <= RST_VAL;
        else if (load)
            q <= load_val;
        else if (en)
            q <= next;
    end

endmodule

// File: rtl/bist_pattern_harness.sv
// BIST harness for a combinational benchmark: an LFSR drives pat_o, a MISR
// compacts resp_i, and the final signature is compared against golden_i
// under a start/abort/done handshake.
module bist_pattern_harness
    import bist_pkg::*;
#(
    parameter int               IN_W      = 51,
    parameter int               OUT_W     = 35,
    parameter int               NUM_PAT   = 1024,
    parameter int               CNT_W     = 16,
    parameter logic [IN_W-1:0]  LFSR_POLY = IN_W'(9),
    parameter logic [IN_W-1:0]  LFSR_SEED = IN_W'(1),
    parameter logic [OUT_W-1:0] MISR_POLY = OUT_W'(5)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [OUT_W-1:0] golden_i,
    input  logic [OUT_W-1:0] resp_i,
    output logic [IN_W-1:0]  pat_o,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [OUT_W-1:0] signature_o,
    output logic [CNT_W-1:0] pat_cnt_o
);

    localparam logic [IN_W-1:0]  SEED = IN_W'(seed_guard(MAX_W'(LFSR_SEED)));
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_PAT - 1);

    state_t state;
    logic   start_ok;
    logic   run_step;

    // A run may begin from IDLE, or from DONE unless abort arrives in the same cycle.
    assign start_ok = start && ((state == IDLE) || ((state == DONE) && !abort));
    // Both registers advance on every RUN cycle that is not being aborted.
    assign run_step = (state == RUN) && !abort;

    galois_reg #(
        .WIDTH   (IN_W),
        .POLY    (LFSR_POLY),
        .RST_VAL (SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .en       (run_step),
        .load     (start_ok),
        .load_val (SEED),
        .xor_in   ('0),
        .q        (pat_o)
    );

    galois_reg #(
        .WIDTH   (OUT_W),
        .POLY    (MISR_POLY),
        .RST_VAL ('0)
    ) u_misr (
        .clk      (clk),
        .rst      (rst),
        .en       (run_step),
        .load     (start_ok),
        .load_val ('0),
        .xor_in   (resp_i),
        .q        (signature_o)
    );

    // Control FSM with registered busy/done/pass and the pattern counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            pat_cnt_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        pass      <= 1'b0;
                        pat_cnt_o <= '0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                        pass  <= 1'b0;
                    end else begin
                        // Saturate so the count cannot wrap when NUM_PAT == 2**CNT_W.
                        if (pat_cnt_o != '1)
                            pat_cnt_o <= pat_cnt_o + 1'b1;
                        if (pat_cnt_o == LAST)
                            state <= COMPARE;
                    end
                end
                COMPARE: begin
                    busy <= 1'b0;
                    if (abort) begin
                        state <= IDLE;
                        done  <= 1'b0;
                        pass  <= 1'b0;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                        pass  <= (signature_o == golden_i);
                    end
                end
                DONE: begin
                    if (abort) begin
                        state <= IDLE;
                        done  <= 1'b0;
                        pass  <= 1'b0;
                    end else if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        pat_cnt_o <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bist_pattern_harness.sv
// Self-checking bench for bist_pattern_harness: small 4-bit instances for
// the LFSR sequence, MISR compaction, handshake and abort cases, plus a
// default-width instance with a zero seed.
module tb_bist_pattern_harness;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- dut_m: MISR / handshake table (NUM_PAT=4)
    logic        m_start = 0, m_abort = 0;
    logic [3:0]  m_golden = 0, m_resp = 0;
    logic [3:0]  m_pat, m_sig;
    logic [15:0] m_cnt;
    logic        m_busy, m_done, m_pass;

    bist_pattern_harness #(.IN_W(4), .OUT_W(4), .NUM_PAT(4), .CNT_W(16),
                           .LFSR_POLY(4'h3), .LFSR_SEED(4'h1), .MISR_POLY(4'h3)) dut_m (
        .clk(clk), .rst(rst), .start(m_start), .abort(m_abort),
        .golden_i(m_golden), .resp_i(m_resp), .pat_o(m_pat), .busy(m_busy),
        .done(m_done), .pass(m_pass), .signature_o(m_sig), .pat_cnt_o(m_cnt));

    // ---------------- dut_l: LFSR sequence (NUM_PAT=16)
    logic        l_start = 0, l_abort = 0;
    logic [3:0]  l_golden = 0, l_resp = 0;
    logic [3:0]  l_pat, l_sig;
    logic [15:0] l_cnt;
    logic        l_busy, l_done, l_pass;

    bist_pattern_harness #(.IN_W(4), .OUT_W(4), .NUM_PAT(16), .CNT_W(16),
                           .LFSR_POLY(4'h3), .LFSR_SEED(4'h1), .MISR_POLY(4'h3)) dut_l (
        .clk(clk), .rst(rst), .start(l_start), .abort(l_abort),
        .golden_i(l_golden), .resp_i(l_resp), .pat_o(l_pat), .busy(l_busy),
        .done(l_done), .pass(l_pass), .signature_o(l_sig), .pat_cnt_o(l_cnt));

    // ---------------- dut_a: abort / rerun / async reset (NUM_PAT=8)
    logic        a_start = 0, a_abort = 0;
    logic [3:0]  a_golden = 4'h9, a_resp = 4'h2;
    logic [3:0]  a_pat, a_sig;
    logic [15:0] a_cnt;
    logic        a_busy, a_done, a_pass;

    bist_pattern_harness #(.IN_W(4), .OUT_W(4), .NUM_PAT(8), .CNT_W(16),
                           .LFSR_POLY(4'h3), .LFSR_SEED(4'h1), .MISR_POLY(4'h3)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .abort(a_abort),
        .golden_i(a_golden), .resp_i(a_resp), .pat_o(a_pat), .busy(a_busy),
        .done(a_done), .pass(a_pass), .signature_o(a_sig), .pat_cnt_o(a_cnt));

    // ---------------- dut_z: default widths, zero seed
    logic        z_start = 0, z_abort = 0;
    logic [34:0] z_golden = '0, z_resp = '0;
    logic [50:0] z_pat;
    logic [34:0] z_sig;
    logic [15:0] z_cnt;
    logic        z_busy, z_done, z_pass;

    bist_pattern_harness #(.LFSR_SEED(51'h0)) dut_z (
        .clk(clk), .rst(rst), .start(z_start), .abort(z_abort),
        .golden_i(z_golden), .resp_i(z_resp), .pat_o(z_pat), .busy(z_busy),
        .done(z_done), .pass(z_pass), .signature_o(z_sig), .pat_cnt_o(z_cnt));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock and sample 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        start;
        logic        abort;
        logic [3:0]  resp;
        logic [3:0]  golden;
        logic [3:0]  pat;
        logic [3:0]  sig;
        logic [15:0] cnt;
        logic        busy;
        logic        done;
        logic        pass;
    } vec_t;

    vec_t       vecs[20];
    logic [3:0] lseq[15];
    int         n;

    initial begin
        // Inputs applied before the edge; expected outputs just after it.
        vecs[0]  = '{1'b1, 1'b0, 4'h1, 4'hF, 4'h1, 4'h0, 16'd0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 4'h1, 4'hF, 4'h2, 4'h1, 16'd1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 4'h1, 4'hF, 4'h4, 4'h3, 16'd2, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 4'h1, 4'hF, 4'h8, 4'h7, 16'd3, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 4'h1, 4'hF, 4'h3, 4'hF, 16'd4, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 4'h1, 4'hF, 4'h3, 4'hF, 16'd4, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 4'h1, 4'hF, 4'h3, 4'hF, 16'd4, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 4'h1, 4'hE, 4'h1, 4'h0, 16'd0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 4'h1, 4'hE, 4'h2, 4'h1, 16'd1, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 4'h1, 4'hE, 4'h4, 4'h3, 16'd2, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 4'h1, 4'hE, 4'h8, 4'h7, 16'd3, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 4'h1, 4'hE, 4'h3, 4'hF, 16'd4, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 4'h1, 4'hE, 4'h3, 4'hF, 16'd4, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 4'h1, 4'hE, 4'h3, 4'hF, 16'd4, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 4'h1, 4'hF, 4'h1, 4'h0, 16'd0, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 4'h1, 4'hF, 4'h2, 4'h1, 16'd1, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 4'h1, 4'hF, 4'h4, 4'h3, 16'd2, 1'b1, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 4'h1, 4'hF, 4'h8, 4'h7, 16'd3, 1'b1, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 4'h1, 4'hF, 4'h3, 4'hF, 16'd4, 1'b1, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 1'b0, 4'h1, 4'hF, 4'h3, 4'hF, 16'd4, 1'b0, 1'b1, 1'b1};

        lseq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
                 4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9};

        // ---- reset values
        #2 rst = 1'b1;
        #10;
        check("rst m pat", m_pat, 4'h1);
        check("rst m sig", m_sig, 4'h0);
        check("rst m cnt", m_cnt, 16'd0);
        check("rst m busy", m_busy, 1'b0);
        check("rst m done", m_done, 1'b0);
        check("rst m pass", m_pass, 1'b0);
        check("rst z pat zero seed", z_pat, 51'h1);
        @(negedge clk) rst = 1'b0;
        tick();
        check("idle m busy", m_busy, 1'b0);

        // ---- table: MISR compaction, pass/fail, DONE start+abort, start during RUN
        for (int i = 0; i < 20; i++) begin
            m_start  = vecs[i].start;
            m_abort  = vecs[i].abort;
            m_resp   = vecs[i].resp;
            m_golden = vecs[i].golden;
            tick();
            check($sformatf("row%0d pat", i),  m_pat,  vecs[i].pat);
            check($sformatf("row%0d sig", i),  m_sig,  vecs[i].sig);
            check($sformatf("row%0d cnt", i),  m_cnt,  vecs[i].cnt);
            check($sformatf("row%0d busy", i), m_busy, vecs[i].busy);
            check($sformatf("row%0d done", i), m_done, vecs[i].done);
            check($sformatf("row%0d pass", i), m_pass, vecs[i].pass);
        end
        m_start = 1'b0;
        m_abort = 1'b0;

        // ---- LFSR sequence, period 15
        l_start = 1'b1;
        tick();
        l_start = 1'b0;
        check("lfsr step0", l_pat, lseq[0]);
        for (int j = 1; j <= 15; j++) begin
            tick();
            check($sformatf("lfsr step%0d", j), l_pat, lseq[j % 15]);
        end
        check("lfsr still busy", l_busy, 1'b1);

        // ---- abort after 3 RUN cycles
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        check("abort cnt start", a_cnt, 16'd0);
        repeat (3) tick();
        check("abort cnt3", a_cnt, 16'd3);
        check("abort busy before", a_busy, 1'b1);
        a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
        check("abort busy", a_busy, 1'b0);
        check("abort done", a_done, 1'b0);
        check("abort pass", a_pass, 1'b0);
        check("abort cnt frozen", a_cnt, 16'd3);
        check("abort sig frozen", a_sig, 4'hE);
        tick();
        check("abort stays idle", a_busy, 1'b0);

        // ---- restart after abort, full length run
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        check("restart pat seed", a_pat, 4'h1);
        check("restart sig", a_sig, 4'h0);
        check("restart cnt", a_cnt, 16'd0);
        n = 0;
        while (!a_done && n < 20) begin
            tick();
            n++;
        end
        check("rerun cycles to done", n, 9);
        check("rerun sig", a_sig, 4'h9);
        check("rerun pass", a_pass, 1'b1);
        check("rerun cnt", a_cnt, 16'd8);

        // ---- async reset between edges mid-run
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (2) tick();
        check("pre-rst busy", a_busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async rst pat", a_pat, 4'h1);
        check("async rst sig", a_sig, 4'h0);
        check("async rst cnt", a_cnt, 16'd0);
        check("async rst busy", a_busy, 1'b0);
        check("async rst done", a_done, 1'b0);
        check("async rst pass", a_pass, 1'b0);
        @(negedge clk) rst = 1'b0;
        tick();
        check("post-rst idle", a_busy, 1'b0);
        check("post-rst z pat", z_pat, 51'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
